// File: rtl/brick_wall_ctrl_if.sv
// brick_wall_ctrl_if
// Hit-query handshake between the ball collision logic (master) and the
// brick wall controller (slave).
//   i_hit_req  master->slave  query valid, held until o_hit_ack
//   i_hit_x    master->slave  query x in pixels
//   i_hit_y    master->slave  query y in pixels
//   o_hit_ack  slave->master  one-cycle pulse, query finished
//   o_hit      slave->master  valid with ack, 1 = a live brick was destroyed
//   o_busy     slave->master  controller is not idle
interface brick_wall_ctrl_if;
    logic        i_hit_req;
    logic [11:0] i_hit_x;
    logic [11:0] i_hit_y;
    logic        o_hit_ack;
    logic        o_hit;
    logic        o_busy;

    modport master (
        output i_hit_req, i_hit_x, i_hit_y,
        input  o_hit_ack, o_hit, o_busy
    );

    modport slave (
        input  i_hit_req, i_hit_x, i_hit_y,
        output o_hit_ack, o_hit, o_busy
    );
endinterface

// File: rtl/brick_wall_ctrl.sv
// brick_wall_ctrl
// Owns the Breakout brick wall: a ROWS x COLS alive bitmap shared by the
// collision logic (serialised hit queries) and the pixel renderer.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          new game: refill the wall, clear the score (pulse)
//   hit_bus          hit-query handshake (slave side of brick_wall_ctrl_if)
//   i_pix_x/i_pix_y  renderer pixel coordinate
//   o_pix_brick      registered: pixel lies on a live brick (mortar excluded)
//   o_score          score, saturating at 511
//   o_bricks_left    number of live bricks
//   o_endgame        wall empty, held until the next start
module brick_wall_ctrl #(
    parameter int COLS    = 8,
    parameter int ROWS    = 4,
    parameter int BW_LOG2 = 6,
    parameter int BH_LOG2 = 4,
    parameter int X0      = 64,
    parameter int Y0      = 48,
    parameter int PTS     = 1,
    localparam int NB     = ROWS * COLS,
    localparam int BL_W   = $clog2(NB + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    brick_wall_ctrl_if.slave    hit_bus,
    input  logic [11:0]         i_pix_x,
    input  logic [11:0]         i_pix_y,
    output logic                o_pix_brick,
    output logic [8:0]          o_score,
    output logic [BL_W-1:0]     o_bricks_left,
    output logic                o_endgame
);

    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [11:0] X_LO = 12'(X0);
    localparam logic [11:0] X_HI = 12'(X0 + (COLS << BW_LOG2));
    localparam logic [11:0] Y_LO = 12'(Y0);
    localparam logic [11:0] Y_HI = 12'(Y0 + (ROWS << BH_LOG2));

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        CHECK,
        RESP,
        FILL
    } state_t;

    state_t            state;
    logic [NB-1:0]     alive;
    logic [11:0]       q_x;
    logic [11:0]       q_y;
    logic              inside_r;
    logic [IDX_W-1:0]  idx_r;
    logic [ROW_W-1:0]  fill_row;
    logic              start_pend;
    logic              ack_r;
    logic              hit_r;
    logic              busy_r;
    logic              pix_r;
    logic [8:0]        score;
    logic [BL_W-1:0]   bricks_left;
    logic              endgame;

    logic              q_inside;
    logic [11:0]       q_dx;
    logic [11:0]       q_dy;
    logic [IDX_W-1:0]  q_idx;
    logic              p_inside;
    logic [11:0]       p_dx;
    logic [11:0]       p_dy;
    logic [IDX_W-1:0]  p_idx;
    logic              p_on_brick;
    logic [9:0]        score_sum;

    // Decode the latched query point and the renderer pixel into a brick
    // index. Offsets are only formed when the point is inside the wall, so
    // the subtraction never wraps and idx stays in range.
    always_comb begin
        q_inside = (q_x >= X_LO) && (q_x < X_HI) && (q_y >= Y_LO) && (q_y < Y_HI);
        q_dx     = q_inside ? (q_x - X_LO) : 12'd0;
        q_dy     = q_inside ? (q_y - Y_LO) : 12'd0;
        q_idx    = IDX_W'(((q_dy >> BH_LOG2) * COLS) + (q_dx >> BW_LOG2));

        p_inside = (i_pix_x >= X_LO) && (i_pix_x < X_HI) &&
                   (i_pix_y >= Y_LO) && (i_pix_y < Y_HI);
        p_dx     = p_inside ? (i_pix_x - X_LO) : 12'd0;
        p_dy     = p_inside ? (i_pix_y - Y_LO) : 12'd0;
        p_idx    = IDX_W'(((p_dy >> BH_LOG2) * COLS) + (p_dx >> BW_LOG2));
        // Zero offset in x or y is the one-pixel mortar line at the brick's
        // left/top edge.
        p_on_brick = p_inside && alive[p_idx] &&
                     (p_dx[BW_LOG2-1:0] != '0) && (p_dy[BH_LOG2-1:0] != '0);

        score_sum = 10'(score) + 10'(PTS);
    end

    // Query FSM plus game state. start_pend remembers a start pulse seen in
    // any state; it is only acted on from IDLE so an in-flight query always
    // completes and is acked before the wall is refilled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            alive       <= '1;
            q_x         <= '0;
            q_y         <= '0;
            inside_r    <= 1'b0;
            idx_r       <= '0;
            fill_row    <= '0;
            start_pend  <= 1'b0;
            ack_r       <= 1'b0;
            hit_r       <= 1'b0;
            busy_r      <= 1'b0;
            score       <= '0;
            bricks_left <= BL_W'(NB);
            endgame     <= 1'b0;
        end else begin
            ack_r <= 1'b0;
            if (i_start) begin
                start_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_pend) begin
                        state       <= FILL;
                        busy_r      <= 1'b1;
                        fill_row    <= '0;
                        score       <= '0;
                        bricks_left <= BL_W'(NB);
                        endgame     <= 1'b0;
                        if (!i_start) begin
                            start_pend <= 1'b0;
                        end
                    end else if (hit_bus.i_hit_req) begin
                        q_x    <= hit_bus.i_hit_x;
                        q_y    <= hit_bus.i_hit_y;
                        state  <= DECODE;
                        busy_r <= 1'b1;
                    end
                end
                DECODE: begin
                    inside_r <= q_inside;
                    idx_r    <= q_idx;
                    state    <= CHECK;
                end
                CHECK: begin
                    if (inside_r && alive[idx_r]) begin
                        alive[idx_r] <= 1'b0;
                        score        <= (score_sum > 10'd511) ? 9'd511 : score_sum[8:0];
                        bricks_left  <= bricks_left - 1'b1;
                        hit_r        <= 1'b1;
                        if (bricks_left == BL_W'(1)) begin
                            endgame <= 1'b1;
                        end
                    end else begin
                        hit_r <= 1'b0;
                    end
                    ack_r <= 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    hit_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                FILL: begin
                    alive[fill_row*COLS +: COLS] <= '1;
                    if (fill_row == ROW_W'(ROWS - 1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        fill_row <= fill_row + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Renderer lookup runs every cycle regardless of the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pix_r <= 1'b0;
        end else begin
            pix_r <= p_on_brick;
        end
    end

    assign hit_bus.o_hit_ack = ack_r;
    assign hit_bus.o_hit     = hit_r;
    assign hit_bus.o_busy    = busy_r;
    assign o_pix_brick       = pix_r;
    assign o_score           = score;
    assign o_bricks_left     = bricks_left;
    assign o_endgame         = endgame;

endmodule

// File: tb/tb_brick_wall_ctrl.sv
// tb_brick_wall_ctrl
// Directed bench for brick_wall_ctrl: reset state, pixel lookup, hit
// queries, wall boundaries, clearing the wall, start during a query and
// asynchronous reset in the middle of a query.
module tb_brick_wall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        pix_brick;
    logic [8:0]  score;
    logic [5:0]  bricks_left;
    logic        endgame;

    int pass_cnt;
    int total_cnt;

    brick_wall_ctrl_if bus ();

    brick_wall_ctrl dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .hit_bus       (bus.slave),
        .i_pix_x       (pix_x),
        .i_pix_y       (pix_y),
        .o_pix_brick   (pix_brick),
        .o_score       (score),
        .o_bricks_left (bricks_left),
        .o_endgame     (endgame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one query from a negedge and waits (bounded) for the ack.
    // Returns at the negedge where ack was seen, with req already dropped.
    task automatic run_query(input logic [11:0] x, input logic [11:0] y,
                             output logic acked, output int lat, output logic hit);
        @(negedge clk);
        bus.i_hit_req = 1'b1;
        bus.i_hit_x   = x;
        bus.i_hit_y   = y;
        acked = 1'b0;
        lat   = 0;
        hit   = 1'b0;
        while (!acked && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.o_hit_ack === 1'b1) begin
                acked = 1'b1;
                hit   = bus.o_hit;
            end
        end
        bus.i_hit_req = 1'b0;
    endtask

    task automatic probe_pixel(input logic [11:0] x, input logic [11:0] y, output logic val);
        @(negedge clk);
        pix_x = x;
        pix_y = y;
        @(posedge clk);
        @(negedge clk);
        val = pix_brick;
    endtask

    task automatic test_reset();
        logic v;
        total_cnt++;
        if (bricks_left !== 6'd32) $display("[TB] FAIL reset_bricks: got %0d expected 32", bricks_left);
        else pass_cnt++;
        total_cnt++;
        if (score !== 9'd0) $display("[TB] FAIL reset_score: got %0d expected 0", score);
        else pass_cnt++;
        total_cnt++;
        if (endgame !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_hit_ack !== 1'b0)
            $display("[TB] FAIL reset_flags: got endgame=%b busy=%b ack=%b expected 0 0 0",
                     endgame, bus.o_busy, bus.o_hit_ack);
        else pass_cnt++;
        probe_pixel(12'd65, 12'd49, v);
        total_cnt++;
        if (v !== 1'b1) $display("[TB] FAIL pix_65_49: got %b expected 1", v);
        else pass_cnt++;
        probe_pixel(12'd64, 12'd49, v);
        total_cnt++;
        if (v !== 1'b0) $display("[TB] FAIL pix_gap_64_49: got %b expected 0", v);
        else pass_cnt++;
        probe_pixel(12'd65, 12'd48, v);
        total_cnt++;
        if (v !== 1'b0) $display("[TB] FAIL pix_gap_65_48: got %b expected 0", v);
        else pass_cnt++;
    endtask

    task automatic test_hit();
        logic acked;
        logic hit;
        logic v;
        int   lat;
        run_query(12'd70, 12'd50, acked, lat, hit);
        total_cnt++;
        if (!acked || lat != 3) $display("[TB] FAIL hit1_latency: got acked=%b lat=%0d expected 1 3", acked, lat);
        else pass_cnt++;
        total_cnt++;
        if (hit !== 1'b1 || score !== 9'd1 || bricks_left !== 6'd31)
            $display("[TB] FAIL hit1_result: got hit=%b score=%0d left=%0d expected 1 1 31", hit, score, bricks_left);
        else pass_cnt++;
        run_query(12'd70, 12'd50, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b0 || score !== 9'd1 || bricks_left !== 6'd31)
            $display("[TB] FAIL hit1_repeat: got acked=%b hit=%b score=%0d left=%0d expected 1 0 1 31",
                     acked, hit, score, bricks_left);
        else pass_cnt++;
        probe_pixel(12'd70, 12'd50, v);
        total_cnt++;
        if (v !== 1'b0) $display("[TB] FAIL pix_dead_brick: got %b expected 0", v);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        logic acked;
        logic hit;
        int   lat;
        run_query(12'd575, 12'd50, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b1 || bricks_left !== 6'd30)
            $display("[TB] FAIL edge_575: got acked=%b hit=%b left=%0d expected 1 1 30", acked, hit, bricks_left);
        else pass_cnt++;
        run_query(12'd576, 12'd50, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b0) $display("[TB] FAIL edge_576: got acked=%b hit=%b expected 1 0", acked, hit);
        else pass_cnt++;
        run_query(12'd10, 12'd10, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b0) $display("[TB] FAIL edge_10_10: got acked=%b hit=%b expected 1 0", acked, hit);
        else pass_cnt++;
        run_query(12'd63, 12'd50, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b0 || score !== 9'd2 || bricks_left !== 6'd30)
            $display("[TB] FAIL edge_63: got acked=%b hit=%b score=%0d left=%0d expected 1 0 2 30",
                     acked, hit, score, bricks_left);
        else pass_cnt++;
    endtask

    task automatic test_clear_wall();
        logic        acked;
        logic        hit;
        logic        v;
        int          lat;
        int          busy_cycles;
        logic [31:0] exp_alive;
        int          exp_score;
        int          exp_left;
        logic        exp_hit;
        // bricks 0 and 7 were destroyed by the earlier tests
        exp_alive = 32'hFFFF_FF7E;
        exp_score = 2;
        exp_left  = 30;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                run_query(12'(64 + c * 64 + 5), 12'(48 + r * 16 + 5), acked, lat, hit);
                exp_hit = exp_alive[r * 8 + c];
                if (exp_hit) begin
                    exp_alive[r * 8 + c] = 1'b0;
                    exp_score++;
                    exp_left--;
                end
                total_cnt++;
                if (!acked || hit !== exp_hit || score !== 9'(exp_score) || bricks_left !== 6'(exp_left))
                    $display("[TB] FAIL clear_r%0d_c%0d: got acked=%b hit=%b score=%0d left=%0d expected 1 %b %0d %0d",
                             r, c, acked, hit, score, bricks_left, exp_hit, exp_score, exp_left);
                else pass_cnt++;
                total_cnt++;
                if (endgame !== (exp_left == 0))
                    $display("[TB] FAIL endgame_r%0d_c%0d: got %b expected %b", r, c, endgame, exp_left == 0);
                else pass_cnt++;
            end
        end
        run_query(12'd300, 12'd60, acked, lat, hit);
        total_cnt++;
        if (!acked || hit !== 1'b0 || endgame !== 1'b1)
            $display("[TB] FAIL empty_wall_query: got acked=%b hit=%b endgame=%b expected 1 0 1", acked, hit, endgame);
        else pass_cnt++;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_busy === 1'b1) busy_cycles++;
        end
        total_cnt++;
        if (busy_cycles != 4) $display("[TB] FAIL fill_busy_cycles: got %0d expected 4", busy_cycles);
        else pass_cnt++;
        total_cnt++;
        if (score !== 9'd0 || bricks_left !== 6'd32 || endgame !== 1'b0)
            $display("[TB] FAIL after_fill: got score=%0d left=%0d endgame=%b expected 0 32 0",
                     score, bricks_left, endgame);
        else pass_cnt++;
        probe_pixel(12'd500, 12'd100, v);
        total_cnt++;
        if (v !== 1'b1) $display("[TB] FAIL pix_after_fill: got %b expected 1", v);
        else pass_cnt++;
    endtask

    task automatic test_start_mid_query();
        logic acked;
        logic hit;
        int   lat;
        @(negedge clk);
        bus.i_hit_req = 1'b1;
        bus.i_hit_x   = 12'd70;
        bus.i_hit_y   = 12'd50;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.o_hit_ack !== 1'b1 || bus.o_hit !== 1'b1 || score !== 9'd1)
            $display("[TB] FAIL start_in_decode_ack: got ack=%b hit=%b score=%0d expected 1 1 1",
                     bus.o_hit_ack, bus.o_hit, score);
        else pass_cnt++;
        bus.i_hit_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.o_busy !== 1'b0) $display("[TB] FAIL idle_before_fill: got busy=%b expected 0", bus.o_busy);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.o_busy !== 1'b1 || score !== 9'd0 || bricks_left !== 6'd32)
            $display("[TB] FAIL fill_entered: got busy=%b score=%0d left=%0d expected 1 0 32",
                     bus.o_busy, score, bricks_left);
        else pass_cnt++;
        // raise a request while the wall is still being refilled
        bus.i_hit_req = 1'b1;
        bus.i_hit_x   = 12'd70;
        bus.i_hit_y   = 12'd50;
        acked = 1'b0;
        hit   = 1'b0;
        lat   = 0;
        while (!acked && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.o_hit_ack === 1'b1) begin
                acked = 1'b1;
                hit   = bus.o_hit;
            end
        end
        bus.i_hit_req = 1'b0;
        total_cnt++;
        if (!acked || lat != 7) $display("[TB] FAIL req_during_fill_latency: got acked=%b lat=%0d expected 1 7", acked, lat);
        else pass_cnt++;
        total_cnt++;
        if (hit !== 1'b1 || score !== 9'd1 || bricks_left !== 6'd31)
            $display("[TB] FAIL req_during_fill_result: got hit=%b score=%0d left=%0d expected 1 1 31",
                     hit, score, bricks_left);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_query();
        logic acked;
        logic hit;
        logic seen_ack;
        int   lat;
        @(negedge clk);
        bus.i_hit_req = 1'b1;
        bus.i_hit_x   = 12'd90;
        bus.i_hit_y   = 12'd70;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.o_hit_ack !== 1'b0 || bus.o_busy !== 1'b0 || score !== 9'd0 ||
            bricks_left !== 6'd32 || endgame !== 1'b0)
            $display("[TB] FAIL async_reset_outputs: got ack=%b busy=%b score=%0d left=%0d endgame=%b expected 0 0 0 32 0",
                     bus.o_hit_ack, bus.o_busy, score, bricks_left, endgame);
        else pass_cnt++;
        bus.i_hit_req = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.o_hit_ack !== 1'b0) seen_ack = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.o_hit_ack !== 1'b0) seen_ack = 1'b1;
        end
        total_cnt++;
        if (seen_ack !== 1'b0) $display("[TB] FAIL aborted_no_ack: got %b expected 0", seen_ack);
        else pass_cnt++;
        run_query(12'd90, 12'd70, acked, lat, hit);
        total_cnt++;
        if (!acked || lat != 3 || hit !== 1'b1 || score !== 9'd1 || bricks_left !== 6'd31)
            $display("[TB] FAIL query_after_reset: got acked=%b lat=%0d hit=%b score=%0d left=%0d expected 1 3 1 1 31",
                     acked, lat, hit, score, bricks_left);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        pix_x         = 12'd0;
        pix_y         = 12'd0;
        bus.i_hit_req = 1'b0;
        bus.i_hit_x   = 12'd0;
        bus.i_hit_y   = 12'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_hit();
        test_boundaries();
        test_clear_wall();
        test_start_mid_query();
        test_reset_mid_query();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
